// File: rtl/alu_flags_reg.sv
// Flag stage behind the ALU: derives carry/zero/overflow from the operands,
// latches them on fi, gates the sum onto the bus and resolves conditional jumps.
module alu_flags_reg #(
    parameter int WIDTH   = 8,
    parameter bit HAS_OVF = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             eo,
    input  logic             fi,
    input  logic             jc_req,
    input  logic             jz_req,
    input  logic             jv_req,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_oe,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flags_valid,
    output logic             jump_taken,
    output logic             alu_mismatch
);

    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   s9;
    logic             c_n, z_n, v_n, mis_n;

    // Flags come from our own sum so a faulty ALU shows up as a mismatch
    // rather than as corrupted flags.
    always_comb begin
        bx    = b ^ {WIDTH{sub}};
        s9    = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
        c_n   = s9[WIDTH];
        z_n   = (s9[WIDTH-1:0] == '0);
        v_n   = HAS_OVF && (a[WIDTH-1] == bx[WIDTH-1]) && (s9[WIDTH-1] != a[WIDTH-1]);
        mis_n = (alu_out != s9[WIDTH-1:0]);
    end

    logic c_q, z_q, v_q, valid_q, mis_q;
    logic c_d, z_d, v_d, valid_d, mis_d;

    always_comb begin
        c_d     = c_q;
        z_d     = z_q;
        v_d     = v_q;
        valid_d = valid_q;
        mis_d   = mis_q;
        if (fi) begin
            c_d     = c_n;
            z_d     = z_n;
            v_d     = v_n;
            valid_d = 1'b1;
            mis_d   = mis_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            v_q     <= 1'b0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            c_q     <= c_d;
            z_q     <= z_d;
            v_q     <= v_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
        end
    end

    assign bus_out      = eo ? alu_out : '0;
    assign bus_oe       = eo;
    assign flag_c       = c_q;
    assign flag_z       = z_q;
    assign flag_v       = v_q;
    assign flags_valid  = valid_q;
    assign alu_mismatch = mis_q;
    // Decision is on the registered flags, so a same-cycle fi cannot affect it.
    assign jump_taken   = valid_q & ((jc_req & c_q) | (jz_req & z_q) | (jv_req & v_q));

endmodule

// File: tb/tb_alu_flags_reg.sv
// Directed bench: stimulus pushes the expected visible outputs for each cycle,
// a negedge monitor pops and compares them.
module tb_alu_flags_reg;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] a = '0, b = '0, alu_out = '0;
    logic       sub = 1'b0, eo = 1'b0, fi = 1'b0;
    logic       jc_req = 1'b0, jz_req = 1'b0, jv_req = 1'b0;
    logic [7:0] bus_out;
    logic       bus_oe, flag_c, flag_z, flag_v, flags_valid, jump_taken, alu_mismatch;

    alu_flags_reg #(.WIDTH(8), .HAS_OVF(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .sub(sub), .alu_out(alu_out),
        .eo(eo), .fi(fi), .jc_req(jc_req), .jz_req(jz_req), .jv_req(jv_req),
        .bus_out(bus_out), .bus_oe(bus_oe), .flag_c(flag_c), .flag_z(flag_z),
        .flag_v(flag_v), .flags_valid(flags_valid), .jump_taken(jump_taken),
        .alu_mismatch(alu_mismatch)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [14:0] vec;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done = 1'b0;

    // vec = {bus[7:0], oe, c, z, v, valid, jmp, mis}
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [14:0] got;
            e   = exp_q.pop_front();
            got = {bus_out, bus_oe, flag_c, flag_z, flag_v, flags_valid, jump_taken, alu_mismatch};
            checks++;
            if (got !== e.vec) begin
                errors++;
                $display("FAIL %s: got bus=%h oe/c/z/v/val/jmp/mis=%b expected bus=%h oe/c/z/v/val/jmp/mis=%b",
                         e.tag, got[14:7], got[6:0], e.vec[14:7], e.vec[6:0]);
            end
        end
    end

    task automatic drv(input logic r, input logic [7:0] ia, input logic [7:0] ib, input logic isub,
                       input logic [7:0] ialu, input logic ieo, input logic ifi,
                       input logic ijc, input logic ijz, input logic ijv);
        @(posedge clk);
        #1;
        rst_n = r; a = ia; b = ib; sub = isub; alu_out = ialu;
        eo = ieo; fi = ifi; jc_req = ijc; jz_req = ijz; jv_req = ijv;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] bus, input logic oe,
                              input logic c, input logic z, input logic v,
                              input logic val, input logic jmp, input logic mis);
        exp_t e;
        e.tag = tag;
        e.vec = {bus, oe, c, z, v, val, jmp, mis};
        exp_q.push_back(e);
    endtask

    initial begin
        logic [7:0] ra, rb, ralu;
        logic       reo;

        // Reset held with fi/eo active: flags stay clear, bus follows eo only.
        drv(0, 8'hFF, 8'h00, 0, 8'hFF, 1, 1, 0, 0, 0);
        expect_out("rst_eo1", 8'hFF, 1, 0, 0, 0, 0, 0, 0);
        drv(0, 8'hFF, 8'h00, 0, 8'hFF, 0, 1, 0, 0, 0);
        expect_out("rst_eo0", 8'h00, 0, 0, 0, 0, 0, 0, 0);

        // 5 - 3: request before flags are valid must not be taken.
        drv(1, 8'h05, 8'h03, 1, 8'h02, 0, 1, 1, 0, 0);
        expect_out("jc_novalid", 8'h00, 0, 0, 0, 0, 0, 0, 0);
        drv(1, 8'h05, 8'h03, 1, 8'h02, 1, 0, 1, 0, 0);
        expect_out("sub_5_3", 8'h02, 1, 1, 0, 0, 1, 1, 0);

        // 3 - 3 then 2 - 3.
        drv(1, 8'h03, 8'h03, 1, 8'h00, 0, 1, 0, 1, 0);
        expect_out("jz_old", 8'h00, 0, 1, 0, 0, 1, 0, 0);
        drv(1, 8'h02, 8'h03, 1, 8'hFF, 0, 1, 0, 1, 0);
        expect_out("sub_3_3", 8'h00, 0, 1, 1, 0, 1, 1, 0);

        // FF + 01 then 7F + 01.
        drv(1, 8'hFF, 8'h01, 0, 8'h00, 0, 1, 1, 1, 0);
        expect_out("sub_2_3_borrow", 8'h00, 0, 0, 0, 0, 1, 0, 0);
        drv(1, 8'h7F, 8'h01, 0, 8'h80, 0, 1, 0, 0, 1);
        expect_out("add_ff_1", 8'h00, 0, 1, 1, 0, 1, 0, 0);
        drv(1, 8'h00, 8'h00, 0, 8'h00, 1, 0, 0, 0, 1);
        expect_out("add_7f_1", 8'h00, 1, 0, 0, 1, 1, 1, 0);

        // Jump with fi in the same cycle uses old flags.
        drv(1, 8'h05, 8'h03, 1, 8'h02, 0, 1, 0, 0, 0);
        expect_out("pre_c", 8'h00, 0, 0, 0, 1, 1, 0, 0);
        drv(1, 8'h02, 8'h03, 1, 8'hFF, 0, 1, 1, 0, 0);
        expect_out("jc_same_cycle", 8'h00, 0, 1, 0, 0, 1, 1, 0);
        drv(1, 8'h00, 8'h00, 0, 8'h00, 0, 0, 1, 0, 0);
        expect_out("jc_next", 8'h00, 0, 0, 0, 0, 1, 0, 0);

        // Mismatch: 08 + 08 = 10 but ALU reports 11, then hold with fi=0.
        drv(1, 8'h08, 8'h08, 0, 8'h11, 1, 1, 0, 0, 0);
        expect_out("pre_mis", 8'h11, 1, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            ra   = 8'($urandom_range(0, 255));
            rb   = 8'($urandom_range(0, 255));
            ralu = 8'($urandom_range(0, 255));
            reo  = 1'($urandom_range(0, 1));
            drv(1, ra, rb, 1'($urandom_range(0, 1)), ralu, reo, 0, 0, 0, 0);
            expect_out("hold", reo ? ralu : 8'h00, reo, 0, 0, 0, 1, 0, 1);
        end

        // Async reset mid-cycle clears before the next clock edge.
        drv(1, 8'hFF, 8'h01, 0, 8'h00, 0, 1, 0, 0, 0);
        expect_out("pre_rst", 8'h00, 0, 0, 0, 0, 1, 0, 1);
        drv(0, 8'hFF, 8'h01, 0, 8'h00, 0, 1, 0, 0, 0);
        expect_out("async_rst", 8'h00, 0, 0, 0, 0, 0, 0, 0);
        drv(1, 8'h03, 8'h03, 1, 8'h00, 0, 1, 0, 1, 0);
        expect_out("post_rst", 8'h00, 0, 0, 0, 0, 0, 0, 0);
        drv(1, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 1, 1);
        expect_out("first_fi", 8'h00, 0, 1, 1, 0, 1, 1, 0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        done = 1'b1;
        $finish;
    end

    initial begin
        #100000;
        if (!done) begin
            $display("FAIL watchdog: timeout reached, required completion");
            $fatal(1);
        end
    end

endmodule
